// File: rtl/ioctl_text_fifo.sv
// ioctl_text_fifo: buffers a text file arriving on the MiSTer ioctl download
// port and hands it out one paced character at a time to the text-feed stage.
// Line endings are folded to CR (LF->CR, CRLF->CR) when XLATE_EOL is set.
// The byte at the head of the FIFO stays counted in `level` until the
// consumer accepts it, so `level` is the number of undelivered bytes.
module ioctl_text_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PACE_DIV   = 4000,
    parameter bit XLATE_EOL  = 1'b1
) (
    input  logic                  clk25,
    input  logic                  rst_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [15:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  overflow,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(PACE_DIV + 1);
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_WAIT = (DEPTH_LOG2 + 1)'(DEPTH - 2);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(PACE_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mem_q [DEPTH];
    logic                    dl_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    ne_q, ne_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [7:0]              out_data_q, out_data_d;
    logic                    overflow_q, overflow_d;
    logic                    cr_seen_q, cr_seen_d;
    logic                    done_q, done_d;

    logic                    start, fall, pop, wr_req, cr_eff, lf_drop;
    logic                    full, push, present;
    logic [7:0]              wr_byte;
    logic [DEPTH_LOG2:0]     base_level;
    logic [DEPTH_LOG2-1:0]   base_wr_ptr, base_rd_ptr;

    // The address only matters to the loader; it is not needed here.
    logic unused_addr;
    assign unused_addr = ^ioctl_addr;

    // Event decode: download edges, handshake, write filtering and head presentation.
    // A download start flushes the FIFO, so a same-cycle write lands in an empty buffer.
    always_comb begin
        start       = ioctl_download & ~dl_q;
        fall        = ~ioctl_download & dl_q;
        pop         = out_valid_q & out_ready & ~start;
        wr_req      = ioctl_download & ioctl_wr;
        cr_eff      = start ? 1'b0 : cr_seen_q;
        lf_drop     = XLATE_EOL & wr_req & (ioctl_dout == 8'h0A) & cr_eff;
        wr_byte     = (XLATE_EOL && ioctl_dout == 8'h0A) ? 8'h0D : ioctl_dout;
        base_level  = start ? '0 : level_q;
        base_wr_ptr = start ? '0 : wr_ptr_q;
        base_rd_ptr = start ? '0 : rd_ptr_q;
        full        = (base_level == LVL_FULL);
        push        = wr_req & ~lf_drop & (~full | pop);
        // ne_q lags level by one cycle, so a freshly written byte waits an extra
        // cycle (memory write then read) before it is shown to the consumer.
        present     = ~start & ~out_valid_q & (cnt_q == '0) & (level_q != '0) & ne_q;
    end

    // Next-state values for pointers, occupancy, pacing and the output register.
    always_comb begin
        wr_ptr_d    = push ? base_wr_ptr + 1'b1 : base_wr_ptr;
        rd_ptr_d    = pop ? base_rd_ptr + 1'b1 : base_rd_ptr;
        level_d     = base_level;
        if (push && !pop) begin
            level_d = base_level + 1'b1;
        end else if (pop && !push) begin
            level_d = base_level - 1'b1;
        end
        ne_d        = ~start & (level_q != '0);
        cnt_d       = cnt_q;
        if (pop) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        out_valid_d = out_valid_q;
        if (start || pop) begin
            out_valid_d = 1'b0;
        end else if (present) begin
            out_valid_d = 1'b1;
        end
        out_data_d  = present ? mem_q[rd_ptr_q] : out_data_q;
        overflow_d  = start ? 1'b0 : overflow_q;
        if (wr_req && !lf_drop && full && !pop) begin
            overflow_d = 1'b1;
        end
        cr_seen_d   = wr_req ? (ioctl_dout == 8'h0D) : cr_eff;
    end

    // Control and output registers, cleared by synchronous active-low reset.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            dl_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ne_q        <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            overflow_q  <= 1'b0;
            cr_seen_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dl_q        <= ioctl_download;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ne_q        <= ne_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            cr_seen_q   <= cr_seen_d;
            done_q      <= done_d;
        end
    end

    // Byte storage; contents need no reset because level gates every read.
    always_ff @(posedge clk25) begin
        if (push) begin
            mem_q[base_wr_ptr] <= wr_byte;
        end
    end

    // FSM state register.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a new download always restarts LOAD; DRAIN ends once everything is delivered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (start)     state_d = ST_LOAD;
                else if (fall) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (start)                                  state_d = ST_LOAD;
                else if (level_q == '0 && !out_valid_q)     state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output: request the one-cycle done pulse on the DRAIN->IDLE transition.
    always_comb begin
        done_d = (state_q == ST_DRAIN) & ~start & (level_q == '0) & ~out_valid_q;
    end

    assign ioctl_wait = ioctl_download & (level_q >= LVL_WAIT);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign level      = level_q;
    assign busy       = ioctl_download | (level_q != '0) | out_valid_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ioctl_text_fifo.sv
// Bench for ioctl_text_fifo: three instances (deep+translate, deep+raw,
// 4-deep+translate) share one stimulus stream and are compared every cycle
// against a queue-based reference model, plus directed sequence checks.
module tb_ioctl_text_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, dl, wr, rdy;
    logic [15:0] addr;
    logic [7:0]  dout;

    logic [7:0]  od [3];
    logic        ov [3];
    logic        wt [3];
    logic        bs [3];
    logic        of [3];
    logic        dn [3];
    logic [4:0]  lv_a, lv_b;
    logic [2:0]  lv_c;

    ioctl_text_fifo #(.DEPTH_LOG2(4), .PACE_DIV(4), .XLATE_EOL(1'b1)) dut_a (
        .clk25(clk), .rst_n(rst_n), .ioctl_download(dl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wt[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy), .level(lv_a),
        .busy(bs[0]), .overflow(of[0]), .done(dn[0]));

    ioctl_text_fifo #(.DEPTH_LOG2(4), .PACE_DIV(4), .XLATE_EOL(1'b0)) dut_b (
        .clk25(clk), .rst_n(rst_n), .ioctl_download(dl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wt[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy), .level(lv_b),
        .busy(bs[1]), .overflow(of[1]), .done(dn[1]));

    ioctl_text_fifo #(.DEPTH_LOG2(2), .PACE_DIV(4), .XLATE_EOL(1'b1)) dut_c (
        .clk25(clk), .rst_n(rst_n), .ioctl_download(dl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wt[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy), .level(lv_c),
        .busy(bs[2]), .overflow(of[2]), .done(dn[2]));

    // Reference model state
    int          m_log2 [3];
    bit          m_xl [3];
    logic [7:0]  mq [3][$];
    int          mt [3][$];
    bit          m_ov [3];
    logic [7:0]  m_od [3];
    int          m_cnt [3];
    bit          m_ovf [3];
    bit          m_cr [3];
    bit          m_done [3];
    int          m_st [3];
    bit          m_dlp;
    int          cyc;

    int          tests, fails;
    logic [7:0]  rx [3][$];
    int          xa [$];
    int          done_cnt_a;
    logic [7:0]  eq [$];

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    function automatic int lvl(int i);
        case (i)
            0:       return int'(lv_a);
            1:       return int'(lv_b);
            default: return int'(lv_c);
        endcase
    endfunction

    // One clock edge of the reference model, using the inputs present at the edge.
    task automatic model_edge();
        bit start, fall, pop, pres, drop;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mq[i].delete(); mt[i].delete();
                m_ov[i] = 0; m_od[i] = 8'h00; m_cnt[i] = 0; m_ovf[i] = 0;
                m_cr[i] = 0; m_done[i] = 0; m_st[i] = 0;
                continue;
            end
            start = dl && !m_dlp;
            fall  = !dl && m_dlp;
            m_done[i] = (m_st[i] == 2) && !start && (mq[i].size() == 0) && !m_ov[i];
            case (m_st[i])
                0: if (start) m_st[i] = 1;
                1: if (start) m_st[i] = 1; else if (fall) m_st[i] = 2;
                default: if (start) m_st[i] = 1;
                         else if (mq[i].size() == 0 && !m_ov[i]) m_st[i] = 0;
            endcase
            pop  = !start && m_ov[i] && rdy;
            pres = !start && !m_ov[i] && (m_cnt[i] == 0) && (mq[i].size() > 0)
                   && (mt[i][0] <= cyc - 2);
            if (start) begin
                mq[i].delete(); mt[i].delete();
                m_ov[i] = 0; m_ovf[i] = 0; m_cr[i] = 0;
            end
            if (pop) m_cnt[i] = 4;
            else if (m_cnt[i] > 0) m_cnt[i]--;
            if (pop) begin
                void'(mq[i].pop_front()); void'(mt[i].pop_front());
                m_ov[i] = 0;
            end
            if (pres) begin
                m_ov[i] = 1;
                m_od[i] = mq[i][0];
            end
            if (dl && wr) begin
                drop = m_xl[i] && (dout == 8'h0A) && m_cr[i];
                m_cr[i] = (dout == 8'h0D);
                if (!drop) begin
                    if (mq[i].size() < (1 << m_log2[i])) begin
                        mq[i].push_back((m_xl[i] && dout == 8'h0A) ? 8'h0D : dout);
                        mt[i].push_back(cyc);
                    end else begin
                        m_ovf[i] = 1;
                    end
                end
            end
        end
        m_dlp = rst_n ? dl : 1'b0;
        cyc++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("level", i, lvl(i), mq[i].size());
            chk("out_valid", i, ov[i], m_ov[i]);
            if (m_ov[i]) chk("out_data", i, od[i], m_od[i]);
            chk("overflow", i, of[i], m_ovf[i]);
            chk("done", i, dn[i], m_done[i]);
            chk("ioctl_wait", i, wt[i], dl && (mq[i].size() >= (1 << m_log2[i]) - 2));
            chk("busy", i, bs[i], dl || (mq[i].size() != 0) || m_ov[i]);
        end
        if (dn[0] === 1'b1) done_cnt_a++;
    endtask

    // Inputs are stable here (changed at the previous negedge); note upcoming transfers.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            if (rst_n && ov[i] && rdy && !(dl && !m_dlp)) begin
                rx[i].push_back(od[i]);
                if (i == 0) xa.push_back(cyc);
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic clear_rx();
        for (int i = 0; i < 3; i++) rx[i].delete();
        xa.delete();
    endtask

    task automatic seq_chk(string tag, int i, logic [7:0] exp [$]);
        chk({tag, "_count"}, i, rx[i].size(), exp.size());
        for (int k = 0; k < exp.size() && k < rx[i].size(); k++)
            chk(tag, i, rx[i][k], exp[k]);
    endtask

    initial begin
        int before_done;
        tests = 0; fails = 0; cyc = 0; m_dlp = 0; done_cnt_a = 0;
        m_log2[0] = 4; m_log2[1] = 4; m_log2[2] = 2;
        m_xl[0] = 1;   m_xl[1] = 0;   m_xl[2] = 1;
        rst_n = 0; dl = 0; wr = 0; rdy = 0; addr = 16'h0; dout = 8'h00;

        // Reset
        run(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_data", i, od[i], 8'h00);
            chk("rst_level", i, lvl(i), 0);
            chk("rst_busy", i, bs[i], 1'b0);
        end
        rst_n = 1;
        run(2);

        // Test 1: "AB\n"
        clear_rx(); done_cnt_a = 0; rdy = 1;
        dl = 1; tick();
        wr = 1;
        dout = 8'h41; addr = 16'd0; tick();
        dout = 8'h42; addr = 16'd1; tick();
        dout = 8'h0A; addr = 16'd2; tick();
        wr = 0; dl = 0;
        run(40);
        eq = {8'h41, 8'h42, 8'h0D}; seq_chk("t1_seq", 0, eq);
        eq = {8'h41, 8'h42, 8'h0A}; seq_chk("t1_seq", 1, eq);
        chk("t1_xfers", 0, xa.size(), 3);
        if (xa.size() >= 3) begin
            chk("t1_gap1", 0, xa[1] - xa[0], 6);
            chk("t1_gap2", 0, xa[2] - xa[1], 6);
        end
        chk("t1_done_pulses", 0, done_cnt_a, 1);

        // Test 2: CR LF LF
        clear_rx();
        dl = 1; tick();
        wr = 1;
        dout = 8'h0D; tick();
        dout = 8'h0A; tick();
        dout = 8'h0A; tick();
        wr = 0; dl = 0;
        run(40);
        eq = {8'h0D, 8'h0D};        seq_chk("t2_seq", 0, eq);
        eq = {8'h0D, 8'h0A, 8'h0A}; seq_chk("t2_seq", 1, eq);
        eq = {8'h0D, 8'h0D};        seq_chk("t2_seq", 2, eq);

        // Test 3: overfill the 4-deep instance
        clear_rx(); rdy = 0;
        dl = 1; tick();
        wr = 1;
        for (int k = 0; k < 6; k++) begin
            dout = 8'(8'h10 + k);
            tick();
        end
        wr = 0;
        chk("t3_level_sat", 2, lv_c, 3'd4);
        chk("t3_overflow", 2, of[2], 1'b1);
        chk("t3_wait", 2, wt[2], 1'b1);
        dl = 0; rdy = 1;
        run(60);
        eq = {8'h10, 8'h11, 8'h12, 8'h13}; seq_chk("t3_seq", 2, eq);
        eq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; seq_chk("t3_seq", 0, eq);

        // Test 4: long stall with out_valid held
        clear_rx(); rdy = 0;
        dl = 1; tick();
        wr = 1; dout = 8'h55; tick();
        wr = 0; dl = 0;
        run(3);
        chk("t4_valid", 0, ov[0], 1'b1);
        run(100);
        chk("t4_hold", 0, od[0], 8'h55);
        chk("t4_still_valid", 0, ov[0], 1'b1);
        rdy = 1;
        run(20);
        eq = {8'h55}; seq_chk("t4_seq", 0, eq);

        // Test 5: restart mid-drain
        clear_rx(); rdy = 0;
        dl = 1; tick();
        wr = 1;
        for (int k = 0; k < 5; k++) begin
            dout = 8'(8'h20 + k);
            tick();
        end
        wr = 0; dl = 0;
        run(3);
        chk("t5_pre_overflow", 2, of[2], 1'b1);
        dl = 1; tick();
        chk("t5_flush_level", 0, lv_a, 5'd0);
        chk("t5_flush_valid", 0, ov[0], 1'b0);
        chk("t5_ovf_clear", 2, of[2], 1'b0);
        wr = 1;
        dout = 8'hA0; tick();
        dout = 8'hA1; tick();
        wr = 0; dl = 0; rdy = 1;
        run(30);
        eq = {8'hA0, 8'hA1}; seq_chk("t5_seq", 0, eq);
        eq = {8'hA0, 8'hA1}; seq_chk("t5_seq", 2, eq);

        // Test 6: reset mid-LOAD
        clear_rx(); rdy = 0;
        dl = 1; tick();
        wr = 1;
        dout = 8'h30; tick();
        dout = 8'h31; tick();
        dout = 8'h32; tick();
        wr = 0; tick();
        rst_n = 0; dl = 0; tick();
        for (int i = 0; i < 3; i++) begin
            chk("t6_level", i, lvl(i), 0);
            chk("t6_valid", i, ov[i], 1'b0);
            chk("t6_data", i, od[i], 8'h00);
            chk("t6_busy", i, bs[i], 1'b0);
            chk("t6_done", i, dn[i], 1'b0);
        end
        rst_n = 1; rdy = 1;
        clear_rx();
        before_done = done_cnt_a;
        run(20);
        chk("t6_no_done", 0, done_cnt_a, before_done);
        chk("t6_no_bytes", 0, rx[0].size(), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) dl = ~dl;
            wr  = dl && ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       dout = 8'h0D;
                1:       dout = 8'h0A;
                default: dout = 8'($urandom);
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        dl = 0; wr = 0; rdy = 1;
        run(150);
        for (int i = 0; i < 3; i++) chk("final_empty", i, lvl(i), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
